// File: rtl/xfire_fpu_bkm_ctrl.sv
// xfire_fpu_bkm_ctrl -- sequencer for the BKM iterative datapath.
//
// Accepts one request at a time through start/ready. op and format are
// captured when the request is accepted. The block then runs the datapath
// through load, a format-dependent number of BKM iterations and a final
// normalization step. It finishes with a one-cycle done pulse. An illegal op
// code or the reserved format skips the datapath and ends at once with err=1.
//
// Ports
//   clk, arst_n, srst   clock, async active-low reset, sync active-high reset
//   enable              global hold; when low, the FSM and all registers freeze
//   start, op, format   request handshake and operands (sampled while ready)
//   abort               cancel the operation in progress; blocks start in IDLE
//   ready, busy         IDLE / (LOAD|ITER|NORM) status
//   dp_load/iter/norm   datapath control strobes
//   dp_k                iteration index (0..ITERS-1)
//   dp_op, dp_format    request captured at acceptance
//   done, err           completion pulse; err is meaningful only with done

`ifndef OPSIZE
`define OPSIZE 3
`endif

module xfire_fpu_bkm_ctrl #(
  parameter int N       = 64,
  parameter int LOG2N   = 6,
  parameter int NUM_OPS = 6
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               srst,
  input  logic               enable,
  input  logic               start,
  input  logic               abort,
  input  logic [`OPSIZE-1:0] op,
  input  logic [1:0]         format,
  output logic               ready,
  output logic               busy,
  output logic               dp_load,
  output logic               dp_iter,
  output logic               dp_norm,
  output logic [LOG2N-1:0]   dp_k,
  output logic [`OPSIZE-1:0] dp_op,
  output logic [1:0]         dp_format,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_NORM,
    S_DONE
  } state_t;

  // Final iteration index for each format.
  localparam logic [LOG2N-1:0] LAST_HALF   = LOG2N'(N / 4 - 1);
  localparam logic [LOG2N-1:0] LAST_SINGLE = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_DOUBLE = LOG2N'(N - 1);
  localparam logic [31:0]      NUM_OPS_U   = NUM_OPS;

  state_t             state, state_nxt;
  logic [LOG2N-1:0]   k_nxt;
  logic [LOG2N-1:0]   last_k;
  logic [`OPSIZE-1:0] op_nxt;
  logic [1:0]         fmt_nxt;
  logic               err_nxt;
  logic               illegal;

  // The iteration limit follows the captured format, not the live input.
  always_comb begin
    unique case (dp_format)
      2'd0:    last_k = LAST_HALF;
      2'd1:    last_k = LAST_SINGLE;
      default: last_k = LAST_DOUBLE;
    endcase
  end

  assign illegal = ({{(32 - `OPSIZE){1'b0}}, op} >= NUM_OPS_U) || (format == 2'd3);

  // NOTE: every signal gets its hold value before the case statement. A path
  // that leaves a combinational output unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    k_nxt     = dp_k;
    op_nxt    = dp_op;
    fmt_nxt   = dp_format;
    err_nxt   = err;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          op_nxt    = op;
          fmt_nxt   = format;
          err_nxt   = illegal;
          state_nxt = illegal ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        k_nxt     = '0;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        // dp_k stops at the last index so it never wraps into the next op.
        if (dp_k == last_k) begin
          state_nxt = S_NORM;
        end else begin
          k_nxt = dp_k + LOG2N'(1);
        end
      end
      S_NORM: state_nxt = S_DONE;
      S_DONE: begin
        err_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides the normal sequence in every non-IDLE state. In IDLE
    // its only effect is the start gating above.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      k_nxt     = '0;
      err_nxt   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      dp_k      <= '0;
      dp_op     <= '0;
      dp_format <= '0;
      err       <= 1'b0;
    end else if (srst) begin
      state     <= S_IDLE;
      dp_k      <= '0;
      dp_op     <= '0;
      dp_format <= '0;
      err       <= 1'b0;
    end else if (enable) begin
      state     <= state_nxt;
      dp_k      <= k_nxt;
      dp_op     <= op_nxt;
      dp_format <= fmt_nxt;
      err       <= err_nxt;
    end
  end

  // Status and strobes are decoded straight from the state register.
  assign ready   = (state == S_IDLE);
  assign dp_load = (state == S_LOAD);
  assign dp_iter = (state == S_ITER);
  assign dp_norm = (state == S_NORM);
  assign done    = (state == S_DONE);
  assign busy    = dp_load | dp_iter | dp_norm;

endmodule

// File: tb/tb_xfire_fpu_bkm_ctrl.sv
// Testbench for xfire_fpu_bkm_ctrl. The bench pushes an expected completion
// record into a scoreboard queue each time it issues a request. The
// per-cycle monitor in tick() compares the record against each done pulse:
// cycle, err, latched op/format and the number of dp_iter cycles. The
// monitor also checks the dp_k sequence during iteration.

`ifndef OPSIZE
`define OPSIZE 3
`endif

module tb_xfire_fpu_bkm_ctrl;

  localparam int N       = 64;
  localparam int LOG2N   = 6;
  localparam int NUM_OPS = 6;
  localparam int OPW     = `OPSIZE;
  localparam int OW      = 7 + LOG2N + OPW + 2;
  localparam logic [OW-1:0] RST_OUTS = OW'(1) << (OW - 1);

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             srst = 1'b0;
  logic             enable = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [OPW-1:0]   op = '0;
  logic [1:0]       format = '0;
  logic             ready, busy, dp_load, dp_iter, dp_norm, done, err;
  logic [LOG2N-1:0] dp_k;
  logic [OPW-1:0]   dp_op;
  logic [1:0]       dp_format;

  xfire_fpu_bkm_ctrl #(.N(N), .LOG2N(LOG2N), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
    .start(start), .abort(abort), .op(op), .format(format),
    .ready(ready), .busy(busy), .dp_load(dp_load), .dp_iter(dp_iter),
    .dp_norm(dp_norm), .dp_k(dp_k), .dp_op(dp_op), .dp_format(dp_format),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    bit             err;
    logic [OPW-1:0] op;
    logic [1:0]     fmt;
    int             iters;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   iter_cnt = 0;

  function automatic logic [OW-1:0] outs();
    return {ready, busy, dp_load, dp_iter, dp_norm, done, err, dp_k, dp_op, dp_format};
  endfunction

  function automatic int iters_of(input logic [1:0] f);
    case (f)
      2'd0:    return N / 4;
      2'd1:    return N / 2;
      default: return N;
    endcase
  endfunction

  // Advance one clock and sample outputs on the falling edge.
  task automatic tick();
    bit   en_edge;
    exp_t e;
    en_edge = enable;
    @(negedge clk);
    cyc++;
    if (!arst_n) begin
      iter_cnt = 0;
      return;
    end
    if (ready) iter_cnt = 0;
    if (dp_iter && en_edge) begin
      tests++;
      if (dp_k !== LOG2N'(iter_cnt)) begin
        fails++;
        $display("FAIL dp_k_seq cyc=%0d got %0d want %0d", cyc, dp_k, iter_cnt);
      end
      iter_cnt++;
    end
    if (done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || err !== e.err || dp_op !== e.op ||
            dp_format !== e.fmt || iter_cnt !== e.iters) begin
          fails++;
          $display("FAIL done_record got cyc=%0d err=%0b op=%0d fmt=%0d iters=%0d want cyc=%0d err=%0b op=%0d fmt=%0d iters=%0d",
                   cyc, err, dp_op, dp_format, iter_cnt, e.cyc, e.err, e.op, e.fmt, e.iters);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_done got none by cyc=%0d want done at cyc=%0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  endtask

  // Drive a request while ready is expected, and record the expected result.
  task automatic issue(input logic [OPW-1:0] o, input logic [1:0] f);
    exp_t e;
    bit   ill;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready got %b want 1", ready);
    end
    op = o; format = f; start = 1'b1;
    ill     = (int'(o) >= NUM_OPS) || (f == 2'd3);
    e.op    = o;
    e.fmt   = f;
    e.err   = ill;
    e.iters = ill ? 0 : iters_of(f);
    e.cyc   = cyc + (ill ? 1 : e.iters + 3);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(ready === 1'b1 && sb.size() == 0) && n < 400) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s_timeout got ready=%b pending=%0d want idle and 0 pending", name, ready, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset_outs got %h want %h", outs(), RST_OUTS);
    end
    tick(); tick();
    arst_n = 1'b1;
    tick();
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset_release got %h want %h", outs(), RST_OUTS);
    end
  endtask

  // Double format walked cycle by cycle against the documented timeline.
  task automatic test_main();
    logic [5:0] want;
    issue(0, 2);
    for (int i = 1; i <= 68; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      want = {i == 68, i >= 1 && i <= 66, i == 1, i >= 2 && i <= 65, i == 66, i == 67};
      tests++;
      if ({ready, busy, dp_load, dp_iter, dp_norm, done} !== want) begin
        fails++;
        $display("FAIL main_t%0d got %b want %b", i, {ready, busy, dp_load, dp_iter, dp_norm, done}, want);
      end
    end
    wait_idle("main");
  endtask

  task automatic test_format();
    issue(3, 0); tick(); start = 1'b0; wait_idle("fmt_half");
    issue(5, 1); tick(); start = 1'b0; wait_idle("fmt_single");
  endtask

  task automatic test_illegal();
    logic [OPW-1:0] ops  [3] = '{6, 1, 7};
    logic [1:0]     fmts [3] = '{2, 3, 0};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], fmts[i]);
      tick();
      start = 1'b0;
      tests++;
      if ({done, err, dp_load, dp_iter, ready} !== 5'b11000) begin
        fails++;
        $display("FAIL illegal%0d_t1 got %b want 11000", i, {done, err, dp_load, dp_iter, ready});
      end
      tick();
      tests++;
      if ({done, ready, busy} !== 3'b010) begin
        fails++;
        $display("FAIL illegal%0d_t2 got %b want 010", i, {done, ready, busy});
      end
    end
  endtask

  task automatic test_abort();
    int c;
    c = cyc;
    issue(2, 2); tick(); start = 1'b0;
    while (cyc < c + 12) tick();
    tests++;
    if (dp_k !== 6'd10 || dp_iter !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre got k=%0d iter=%b want k=10 iter=1", dp_k, dp_iter);
    end
    abort = 1'b1; start = 1'b1; op = 4; format = 0;
    sb.delete();
    tick();
    tests++;
    if ({ready, busy, done, dp_k, dp_op} !== {3'b100, 6'd0, 3'd2}) begin
      fails++;
      $display("FAIL abort_idle got %b want %b", {ready, busy, done, dp_k, dp_op}, {3'b100, 6'd0, 3'd2});
    end
    abort = 1'b0; start = 1'b0;
    tick();
    tests++;
    if ({ready, busy, dp_load, dp_op, dp_format} !== {3'b100, 3'd2, 2'd2}) begin
      fails++;
      $display("FAIL abort_start_ignored got %b want %b", {ready, busy, dp_load, dp_op, dp_format}, {3'b100, 3'd2, 2'd2});
    end
    repeat (10) tick();
    // Abort while idle only blocks the start.
    abort = 1'b1; start = 1'b1; op = 5; format = 1;
    tick();
    abort = 1'b0; start = 1'b0;
    tests++;
    if ({ready, dp_load, done, dp_op} !== {3'b100, 3'd2}) begin
      fails++;
      $display("FAIL abort_blocks_start got %b want %b", {ready, dp_load, done, dp_op}, {3'b100, 3'd2});
    end
    tick();
  endtask

  task automatic test_enable();
    int c;
    c = cyc;
    issue(1, 2); tick(); start = 1'b0;
    while (cyc < c + 22) tick();
    tests++;
    if (dp_k !== 6'd20) begin
      fails++;
      $display("FAIL enable_pre got k=%0d want 20", dp_k);
    end
    sb[$].cyc += 5;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (dp_k !== 6'd20 || dp_iter !== 1'b1) begin
        fails++;
        $display("FAIL enable_hold%0d got k=%0d iter=%b want k=20 iter=1", i, dp_k, dp_iter);
      end
    end
    enable = 1'b1;
    wait_idle("enable");
  endtask

  task automatic test_reset_mid();
    int c;
    c = cyc;
    issue(3, 2); tick(); start = 1'b0;
    while (cyc < c + 32) tick();
    tests++;
    if (dp_k !== 6'd30) begin
      fails++;
      $display("FAIL arst_pre got k=%0d want 30", dp_k);
    end
    arst_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL arst_mid got %h want %h", outs(), RST_OUTS);
    end
    tick(); tick();
    arst_n = 1'b1;
    tick();
    c = cyc;
    issue(5, 1); tick(); start = 1'b0;
    while (cyc < c + 7) tick();
    tests++;
    if (dp_k !== 6'd5) begin
      fails++;
      $display("FAIL srst_pre got k=%0d want 5", dp_k);
    end
    srst = 1'b1;
    sb.delete();
    tick();
    srst = 1'b0;
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL srst_mid got %h want %h", outs(), RST_OUTS);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int   c0;
    exp_t e;
    c0 = cyc;
    issue(1, 1);
    for (int k = 1; k < 3; k++) begin
      e.cyc = c0 + 35 + 36 * k; e.err = 1'b0; e.op = 2; e.fmt = 1; e.iters = N / 2;
      sb.push_back(e);
    end
    while (cyc < c0 + 110) begin
      tick();
      if (cyc == c0 + 5) op = 2;
      if (cyc == c0 + 10) begin
        tests++;
        if (dp_op !== 3'd1) begin
          fails++;
          $display("FAIL b2b_op_busy got %0d want 1", dp_op);
        end
      end
      if (cyc == c0 + 73) begin
        start = 1'b0;
        tests++;
        if (dp_op !== 3'd2 || dp_load !== 1'b1) begin
          fails++;
          $display("FAIL b2b_third got op=%0d load=%b want op=2 load=1", dp_op, dp_load);
        end
      end
    end
    wait_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_main();
    test_format();
    test_illegal();
    test_abort();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
